// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle LEGv8 datapath.
// Owns the PC, fetches over an ImemReq/ImemAck handshake, holds the fetched
// word for decode and drives SignExtender's Imm/Ctrl. The branch target uses
// the BusImm value that SignExtender returns combinationally.
// Optional build macro FETCH_BRANCH_COUNT_EN adds a saturating TakenCount output.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        ResetL,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [25:0] Imm,
    output logic [1:0]  Ctrl,
    input  logic [63:0] BusImm,
    input  logic        RegZero,
`ifdef FETCH_BRANCH_COUNT_EN
    output logic [31:0] TakenCount,
`endif
    output logic [63:0] PC
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic        capture;
    logic        accept;
    logic        is_b;
    logic        is_cb;
    logic        is_mem;
    logic        taken;
    logic [63:0] next_pc;

    // Immediate format decode from the latched instruction
    always_comb begin
        is_b   = (Instr[31:26] == 6'b000101);
        is_cb  = (Instr[31:25] == 7'b1011010);
        is_mem = (Instr[31:23] == 9'b111110000) && !Instr[21];
        if (is_b)
            Ctrl = 2'b10;
        else if (is_cb)
            Ctrl = 2'b11;
        else if (is_mem)
            Ctrl = 2'b01;
        else
            Ctrl = 2'b00;
    end

    // Branch resolution and next-PC selection (Instr[24] set means CBNZ)
    always_comb begin
        taken   = is_b || (is_cb && (Instr[24] ? !RegZero : RegZero));
        next_pc = taken ? (PC + BusImm) : (PC + 64'(PC_STEP));
    end

    // Next-state logic; FETCH with ImemReq still low is the first cycle out of
    // reset, where an acknowledge belongs to an abandoned transaction
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (!ImemReq)
                    next_state = FETCH;
                else if (ImemAck)
                    next_state = ISSUE;
                else
                    next_state = WAIT;
            end
            WAIT:    next_state = ImemAck ? ISSUE : WAIT;
            ISSUE:   next_state = InstrReady ? FETCH : ISSUE;
            default: next_state = FETCH;
        endcase
    end

    assign capture    = ImemAck && ImemReq && ((state == FETCH) || (state == WAIT));
    assign accept     = (state == ISSUE) && InstrReady;
    assign InstrValid = (state == ISSUE);
    assign ImemAddr   = PC;
    assign Imm        = Instr[25:0];

    // Sequencer state, registered request, instruction latch and PC update
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state   <= FETCH;
            ImemReq <= 1'b0;
            Instr   <= '0;
            PC      <= RESET_PC;
        end else begin
            state   <= next_state;
            ImemReq <= (next_state != ISSUE);
            if (capture)
                Instr <= ImemData;
            if (accept)
                PC <= next_pc;
        end
    end

`ifdef FETCH_BRANCH_COUNT_EN
    // Saturating count of accepted taken branches
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL)
            TakenCount <= '0;
        else if (accept && taken && (TakenCount != '1))
            TakenCount <= TakenCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Models instruction memory, decode acceptance and SignExtender.
// Counter checks are active when FETCH_BRANCH_COUNT_EN is defined.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        ResetL;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic [25:0] Imm;
    logic [1:0]  Ctrl;
    logic [63:0] BusImm;
    logic        RegZero;
    logic [63:0] PC;
`ifdef FETCH_BRANCH_COUNT_EN
    logic [31:0] TakenCount;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [63:0] cur_pc;
    int unsigned exp_count = 0;

    fetch_unit #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
        .CLK        (CLK),
        .ResetL     (ResetL),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemData   (ImemData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Imm        (Imm),
        .Ctrl       (Ctrl),
        .BusImm     (BusImm),
        .RegZero    (RegZero),
`ifdef FETCH_BRANCH_COUNT_EN
        .TakenCount (TakenCount),
`endif
        .PC         (PC)
    );

    always #5 CLK = ~CLK;

    // SignExtender model: B/CB offsets are word offsets shifted left by 2
    always_comb begin
        case (Ctrl)
            2'b10:   BusImm = {{36{Imm[25]}}, Imm, 2'b00};
            2'b11:   BusImm = {{43{Imm[23]}}, Imm[23:5], 2'b00};
            2'b01:   BusImm = {{55{Imm[20]}}, Imm[20:12]};
            default: BusImm = {52'b0, Imm[21:10]};
        endcase
    end

    // One full instruction: fetch with ack delay, issue with stall, accept
    task automatic run_instr(input string name, input logic [31:0] data,
                             input int unsigned delay, input logic [1:0] exp_ctrl,
                             input int unsigned stall, input logic rz,
                             input logic [63:0] exp_next, input bit exp_taken);
        int unsigned n = 0;
        while (ImemReq !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (ImemReq !== 1'b1 || ImemAddr !== cur_pc) begin
            fails++;
            $display("FAIL %s request: ImemReq=%b ImemAddr=%h, expected 1 %h", name, ImemReq, ImemAddr, cur_pc);
        end
        for (int unsigned i = 0; i < delay; i++) begin
            ImemAck = 1'b0;
            @(negedge CLK);
            tests++;
            if (ImemReq !== 1'b1 || InstrValid !== 1'b0 || PC !== cur_pc) begin
                fails++;
                $display("FAIL %s wait%0d: ImemReq=%b InstrValid=%b PC=%h, expected 1 0 %h", name, i, ImemReq, InstrValid, PC, cur_pc);
            end
        end
        ImemAck  = 1'b1;
        ImemData = data;
        @(negedge CLK);
        ImemAck  = 1'b0;
        ImemData = 32'hDEADBEEF;
        tests++;
        if (InstrValid !== 1'b1 || Instr !== data || Imm !== data[25:0] || Ctrl !== exp_ctrl || ImemReq !== 1'b0) begin
            fails++;
            $display("FAIL %s issue: valid=%b Instr=%h Imm=%h Ctrl=%b req=%b, expected 1 %h %h %b 0", name, InstrValid, Instr, Imm, Ctrl, ImemReq, data, data[25:0], exp_ctrl);
        end
        for (int unsigned i = 0; i < stall; i++) begin
            InstrReady = 1'b0;
            ImemAck    = (i == 1);
            RegZero    = ~rz;
            @(negedge CLK);
            tests++;
            if (InstrValid !== 1'b1 || Instr !== data || Ctrl !== exp_ctrl || ImemReq !== 1'b0 || PC !== cur_pc) begin
                fails++;
                $display("FAIL %s stall%0d: valid=%b Instr=%h Ctrl=%b req=%b PC=%h, expected 1 %h %b 0 %h", name, i, InstrValid, Instr, Ctrl, ImemReq, PC, data, exp_ctrl, cur_pc);
            end
        end
        ImemAck    = 1'b0;
        InstrReady = 1'b1;
        RegZero    = rz;
        @(negedge CLK);
        InstrReady = 1'b0;
        RegZero    = ~rz;
        tests++;
        if (PC !== exp_next || ImemAddr !== exp_next || InstrValid !== 1'b0 || ImemReq !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: PC=%h ImemAddr=%h valid=%b req=%b, expected %h %h 0 1", name, PC, ImemAddr, InstrValid, ImemReq, exp_next, exp_next);
        end
        cur_pc = exp_next;
        if (exp_taken)
            exp_count++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        tests++;
        if (PC !== 64'h0 || InstrValid !== 1'b0 || ImemReq !== 1'b0 || Instr !== 32'h0 || Imm !== 26'h0 || Ctrl !== 2'b00) begin
            fails++;
            $display("FAIL reset: PC=%h valid=%b req=%b Instr=%h Imm=%h Ctrl=%b, expected all zero", PC, InstrValid, ImemReq, Instr, Imm, Ctrl);
        end
        ResetL = 1'b1;
        @(negedge CLK);
        tests++;
        if (ImemReq !== 1'b1 || ImemAddr !== 64'h0 || InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: req=%b ImemAddr=%h valid=%b, expected 1 0 0", ImemReq, ImemAddr, InstrValid);
        end
        cur_pc = 64'h0;
    endtask

    task automatic test_sequential();
        run_instr("addi_wait3", 32'h91000C20, 3, 2'b00, 0, 1'b0, 64'h4, 0);
        for (int unsigned i = 0; i < 3; i++)
            run_instr("addi_seq", 32'h91000C20, i, 2'b00, 0, 1'b0, cur_pc + 64'd4, 0);
    endtask

    task automatic test_branch();
        run_instr("b_fwd", 32'h14000003, 0, 2'b10, 0, 1'b0, 64'h1C, 1);
    endtask

    task automatic test_cbz_cbnz();
        run_instr("addi_pad", 32'h91000C20, 1, 2'b00, 0, 1'b0, 64'h20, 0);
        run_instr("cbz_taken", 32'hB4000060, 0, 2'b11, 0, 1'b1, 64'h2C, 1);
        run_instr("cbz_not", 32'hB4000060, 2, 2'b11, 1, 1'b0, 64'h30, 0);
        run_instr("cbnz_taken", 32'hB5000060, 0, 2'b11, 0, 1'b0, 64'h3C, 1);
        run_instr("cbnz_not", 32'hB5000060, 1, 2'b11, 0, 1'b1, 64'h40, 0);
    endtask

    task automatic test_backward_stall();
        for (int unsigned i = 0; i < 48; i++)
            run_instr("walk", 32'h8B020020, 0, 2'b00, 0, 1'b0, cur_pc + 64'd4, 0);
        run_instr("b_back_stall", 32'h17FFFFFC, 0, 2'b10, 5, 1'b0, 64'hF0, 1);
    endtask

    task automatic test_ldur();
        run_instr("ldur", 32'hF8400000, 1, 2'b01, 0, 1'b0, 64'hF4, 0);
`ifdef FETCH_BRANCH_COUNT_EN
        tests++;
        if (TakenCount !== 32'(exp_count) || TakenCount !== 32'd4) begin
            fails++;
            $display("FAIL taken_count: TakenCount=%0d, expected 4", TakenCount);
        end
`endif
    endtask

    task automatic test_reset_midwait();
        run_instr("b_to_40", 32'h17FFFFD3, 0, 2'b10, 0, 1'b0, 64'h40, 1);
        ImemAck = 1'b0;
        @(negedge CLK);
        tests++;
        if (PC !== 64'h40 || ImemReq !== 1'b1 || InstrValid !== 1'b0) begin
            fails++;
            $display("FAIL midwait: PC=%h req=%b valid=%b, expected 40 1 0", PC, ImemReq, InstrValid);
        end
        #2;
        ResetL   = 1'b0;
        ImemAck  = 1'b1;
        ImemData = 32'h14000003;
        #1;
        tests++;
        if (PC !== 64'h0 || InstrValid !== 1'b0 || ImemReq !== 1'b0 || Instr !== 32'h0 || Ctrl !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: PC=%h valid=%b req=%b Instr=%h Ctrl=%b, expected 0 0 0 0 00", PC, InstrValid, ImemReq, Instr, Ctrl);
        end
        @(negedge CLK);
        ResetL = 1'b1;
        @(negedge CLK);
        ImemAck = 1'b0;
        tests++;
        if (ImemReq !== 1'b1 || ImemAddr !== 64'h0 || InstrValid !== 1'b0 || Instr !== 32'h0) begin
            fails++;
            $display("FAIL late_ack: req=%b ImemAddr=%h valid=%b Instr=%h, expected 1 0 0 0", ImemReq, ImemAddr, InstrValid, Instr);
        end
        cur_pc = 64'h0;
`ifdef FETCH_BRANCH_COUNT_EN
        tests++;
        if (TakenCount !== 32'd0) begin
            fails++;
            $display("FAIL count_reset: TakenCount=%0d, expected 0", TakenCount);
        end
`endif
        run_instr("addi_after_reset", 32'h91000C20, 0, 2'b00, 0, 1'b0, 64'h4, 0);
    endtask

    initial begin
        ResetL     = 1'b0;
        ImemAck    = 1'b0;
        ImemData   = '0;
        InstrReady = 1'b0;
        RegZero    = 1'b0;
        cur_pc     = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_cbz_cbnz();
        test_backward_stall();
        test_ldur();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle LEGv8 datapath; sits directly upstream of SignExtender.
- Owns the PC and fetches 32-bit instructions over a req/ack memory handshake, then presents each instruction to decode.
- Drives SignExtender's Imm[25:0] and Ctrl[1:0] inputs.
- Consumes SignExtender's BusImm, already shifted left by 2 for B and CB formats, to compute the branch target.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- ResetL  input  1  asynchronous active-low reset.
- ImemReq  output  1  fetch request to instruction memory.
- ImemAddr  output  64  fetch address; always equals PC.
- ImemAck  input  1  memory returns ImemData this cycle.
- ImemData  input  32  instruction word.
- Instr  output  32  latched instruction to decode.
- InstrValid  output  1  Instr/Imm/Ctrl valid.
- InstrReady  input  1  decode/execute accepts the instruction this cycle.
- Imm  output  26  equals Instr[25:0]; drives SignExtender.Imm.
- Ctrl  output  2  immediate format for SignExtender.Ctrl.
- BusImm  input  64  sign-extended immediate returned by SignExtender (combinational from Imm/Ctrl).
- RegZero  input  1  Rt==0 flag from register file, sampled for CBZ/CBNZ.
- PC  output  64  current PC.

Behaviour:
- Reset (async, ResetL=0):
  - PC=RESET_PC, state=FETCH.
  - Instr=0, InstrValid=0, ImemReq=0.
  - Imm=0, Ctrl=2'b00.
  - A reset mid-transaction abandons it; a late ImemAck is ignored because the FSM is in FETCH with ImemReq low until the first post-reset edge.
- FSM states: FETCH, WAIT, ISSUE.
- FETCH:
  - ImemReq=1, ImemAddr=PC.
  - ImemAck=1 in the same cycle latches ImemData into Instr and moves to ISSUE (zero-wait memory).
  - Otherwise move to WAIT.
- WAIT:
  - ImemReq held 1, PC stable.
  - ImemAck=1 latches ImemData and moves to ISSUE; otherwise stay.
- ISSUE:
  - InstrValid=1, ImemReq=0; Instr, Imm and Ctrl held stable while InstrReady=0 (no timeout).
  - InstrReady=1 updates PC to NextPC, drops InstrValid and moves to FETCH.
  - Minimum 2 cycles per instruction.
- Ctrl decode (combinational from latched Instr):
  - Instr[31:26]=000101 (B) -> 2'b10.
  - Instr[31:25]=1011010 (CBZ/CBNZ) -> 2'b11.
  - Instr[31:21]=111110000x0 (STUR/LDUR) -> 2'b01.
  - Everything else, including ADDI/SUBI and R-type -> 2'b00.
- Branch rules:
  - Taken = B, OR (CBZ AND RegZero), OR (CBNZ AND !RegZero); Instr[24] distinguishes CBNZ=1 from CBZ=0.
  - NextPC = Taken ? PC+BusImm : PC+PC_STEP.
  - 64-bit modulo arithmetic; wrap-around past 2^64 is silent; a negative BusImm moves backwards.
- RegZero and BusImm are sampled only on the ISSUE cycle that has InstrReady=1; earlier values are don't-care.
- ImemAck in ISSUE is ignored.

Optional Feature:
- Macro FETCH_BRANCH_COUNT_EN.
- Defined:
  - Adds output TakenCount[31:0], reset to 0.
  - Increments by 1 on each accepted ISSUE cycle with Taken=1.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: ResetL=0 asserted mid-WAIT at PC=0x40 -> immediately PC=0, InstrValid=0, ImemReq=0. Release -> next cycle ImemReq=1, ImemAddr=0.
- Sequential fetch, ADDI:
  - Stimulus: ImemData=32'h91000C20 with a 3-cycle ack delay, InstrReady=1.
  - Response: Ctrl=00, Imm=26'h1000C20, PC 0x0 -> 0x4 after accept; ImemReq held through WAIT.
- B, target 12 bytes ahead:
  - Stimulus: PC=0x10, ImemData=32'h14000003, bench models SignExtender so BusImm=64'd12.
  - Response: Ctrl=10, PC -> 0x1C.
- CBZ/CBNZ:
  - CBZ 32'hB4000060 (BusImm=12) at PC=0x20: RegZero=1 -> PC=0x2C; RegZero=0 -> PC=0x24.
  - CBNZ 32'hB5000060, RegZero=0 -> PC=0x2C.
- Backward branch plus stall:
  - Stimulus: PC=0x100, B with BusImm=64'hFFFFFFFFFFFFFFF0; hold InstrReady=0 for 5 cycles.
  - Response: Instr/Ctrl stable and InstrValid=1 throughout; on accept PC=0xF0.
- LDUR plus counter:
  - LDUR 32'hF8400000 -> Ctrl=01, PC+4.
  - With FETCH_BRANCH_COUNT_EN, after the scenarios above TakenCount=4: B, CBZ-taken and CBNZ-taken from the CBZ/CBNZ scenario, plus the backward B.
